// File: rtl/cla_nibble_seq.sv
// -----------------------------------------------------------------------------
// cla_nibble_seq
//
// Adds two WIDTH-bit operands using one shared 4-bit carry-lookahead slice.
// The slice is used once per nibble, least significant nibble first. The
// carry out of each nibble feeds the carry-in of the next nibble.
//
// Parameters
//   WIDTH   operand/sum width (multiple of 4, >= 4); NIB = WIDTH/4 steps
//   SETTLE  cycles each nibble is held on the slice before capture (>= 1)
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start             add request, sampled only while idle
//   a_in, b_in, cin   operands and carry-in, latched when start is accepted
//   busy              high from acceptance until the cycle after done
//   done              one-cycle pulse; sum/cout/ovf valid from this cycle
//   sum, cout, ovf    result, carry out of MSB, signed overflow
//   cla_a, cla_b      nibble operands driven to the shared slice
//   cla_c             carry-in driven to the shared slice
//   cla_carry         slice carries; cla_carry[i] = carry out of bit i
// -----------------------------------------------------------------------------
module cla_nibble_seq #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [3:0]       cla_a,
  output logic [3:0]       cla_b,
  output logic             cla_c,
  input  logic [3:0]       cla_carry
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry_reg;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    nidx;
  logic [CW-1:0]    cnt;

  // Sum bit i is a^b^carry-into-bit-i; the slice only reports carries out,
  // so the carry-in vector is the slice carries shifted up by one with the
  // nibble carry-in at the bottom.
  function automatic logic [3:0] sum_nib(input logic [3:0] a,
                                         input logic [3:0] b,
                                         input logic [3:0] cvec);
    return a ^ b ^ cvec;
  endfunction

  assign nidx = idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      cla_a     <= 4'h0;
      cla_b     <= 4'h0;
      cla_c     <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            opa       <= a_in;
            opb       <= b_in;
            carry_reg <= cin;
            idx       <= '0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            // Present nibble 0 to the slice in the first RUN cycle.
            cla_a     <= a_in[3:0];
            cla_b     <= b_in[3:0];
            cla_c     <= cin;
            busy      <= 1'b1;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (cnt == CW'(SETTLE - 1)) begin
            sum[{idx, 2'b00} +: 4] <= sum_nib(cla_a, cla_b, {cla_carry[2:0], carry_reg});
            carry_reg <= cla_carry[3];
            cnt       <= '0;
            if (idx == IW'(NIB - 1)) begin
              // Top nibble: carry out is the result carry only, never wrapped.
              cout  <= cla_carry[3];
              ovf   <= cla_carry[2] ^ cla_carry[3];
              done  <= 1'b1;
              cla_a <= 4'h0;
              cla_b <= 4'h0;
              cla_c <= 1'b0;
              state <= S_DONE;
            end else begin
              idx   <= nidx;
              cla_a <= opa[{nidx, 2'b00} +: 4];
              cla_b <= opb[{nidx, 2'b00} +: 4];
              cla_c <= cla_carry[3];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_nibble_seq.sv
module tb_cla_nibble_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        start2;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        cin;

  logic        busy1, done1, cout1, ovf1, cla_c1;
  logic [15:0] sum1;
  logic [3:0]  cla_a1, cla_b1, cla_carry1;

  logic        busy2, done2, cout2, ovf2, cla_c2;
  logic [15:0] sum2;
  logic [3:0]  cla_a2, cla_b2, cla_carry2;

  int n_checks = 0;
  int n_fail   = 0;

  always #25 clk = ~clk;

  // Real 4-bit carry-lookahead slice: carries from generate/propagate terms.
  function automatic logic [3:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [3:0] g, p, cy;
    g = a & b;
    p = a ^ b;
    cy[0] = g[0] | (p[0] & c);
    cy[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    cy[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    cy[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c);
    return cy;
  endfunction

  assign cla_carry1 = cla4(cla_a1, cla_b1, cla_c1);
  assign cla_carry2 = cla4(cla_a2, cla_b2, cla_c2);

  cla_nibble_seq #(.WIDTH(16), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1),
    .cla_a(cla_a1), .cla_b(cla_b1), .cla_c(cla_c1), .cla_carry(cla_carry1)
  );

  cla_nibble_seq #(.WIDTH(16), .SETTLE(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a_in(a_in), .b_in(b_in), .cin(cin),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2),
    .cla_a(cla_a2), .cla_b(cla_b2), .cla_c(cla_c2), .cla_carry(cla_carry2)
  );

  // Cycle k = the cycle following edge k-1, where edge 0 accepts start.
  // Called at the negedge of cycle 1; returns first done cycle (0 = none).
  task automatic wait_done1(output int lat, output int width);
    lat = 0;
    width = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k > 1) @(negedge clk);
      if (done1 === 1'b1) begin
        if (lat == 0) lat = k;
        width++;
      end else if (lat != 0) begin
        break;
      end
    end
  endtask

  // Present operands and pulse start across one edge (edge 0).
  task automatic launch1(input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; a_in = 16'h0; b_in = 16'h0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy1, done1, cout1, ovf1, cla_c1} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: busy/done/cout/ovf/cla_c got %b need 00000", {busy1, done1, cout1, ovf1, cla_c1});
    end
    n_checks++;
    if (sum1 !== 16'h0) begin n_fail++; $display("FAIL reset_sum: got %h need 0000", sum1); end
    n_checks++;
    if ({cla_a1, cla_b1} !== 8'h00) begin n_fail++; $display("FAIL reset_cla_ab: got %h need 00", {cla_a1, cla_b1}); end
    n_checks++;
    if ({busy2, done2, sum2, cla_a2, cla_b2, cla_c2} !== 27'b0) begin
      n_fail++; $display("FAIL reset_dut2: got %h need 0", {busy2, done2, sum2, cla_a2, cla_b2, cla_c2});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_add;
    int lat, width;
    launch1(16'h1234, 16'h4321, 1'b0);
    n_checks++;
    if (busy1 !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b need 1", busy1); end
    wait_done1(lat, width);
    n_checks++;
    if (lat != 5) begin n_fail++; $display("FAIL basic_latency: got cycle %0d need 5", lat); end
    n_checks++;
    if (width != 1) begin n_fail++; $display("FAIL basic_done_width: got %0d need 1", width); end
    n_checks++;
    if ({sum1, cout1, ovf1} !== {16'h5555, 2'b00}) begin
      n_fail++; $display("FAIL basic_result: got sum=%h cout=%b ovf=%b need 5555 0 0", sum1, cout1, ovf1);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy1, sum1, cla_a1, cla_b1, cla_c1} !== {1'b0, 16'h5555, 9'h0}) begin
      n_fail++; $display("FAIL basic_hold_idle: got busy=%b sum=%h cla=%h/%h/%b need 0 5555 0/0/0",
                         busy1, sum1, cla_a1, cla_b1, cla_c1);
    end
  endtask

  task automatic test_carry_chain;
    int lat, width;
    launch1(16'hFFFF, 16'h0000, 1'b1);
    wait_done1(lat, width);
    n_checks++;
    if ({lat, sum1, cout1, ovf1} !== {32'd5, 16'h0000, 2'b10}) begin
      n_fail++; $display("FAIL carry_chain: got lat=%0d sum=%h cout=%b ovf=%b need 5 0000 1 0", lat, sum1, cout1, ovf1);
    end
  endtask

  task automatic test_overflow;
    int lat, width;
    launch1(16'h7FFF, 16'h0001, 1'b0);
    wait_done1(lat, width);
    n_checks++;
    if ({lat, sum1, cout1, ovf1} !== {32'd5, 16'h8000, 2'b01}) begin
      n_fail++; $display("FAIL ovf_pos: got lat=%0d sum=%h cout=%b ovf=%b need 5 8000 0 1", lat, sum1, cout1, ovf1);
    end
    launch1(16'h8000, 16'h8000, 1'b0);
    wait_done1(lat, width);
    n_checks++;
    if ({lat, sum1, cout1, ovf1} !== {32'd5, 16'h0000, 2'b11}) begin
      n_fail++; $display("FAIL ovf_neg: got lat=%0d sum=%h cout=%b ovf=%b need 5 0000 1 1", lat, sum1, cout1, ovf1);
    end
  endtask

  task automatic test_start_in_run;
    int lat, width;
    launch1(16'h1234, 16'h4321, 1'b0);
    // Cycle 1 now; re-request with new operands in cycles 2-3.
    @(negedge clk);
    a_in = 16'hFFFF; b_in = 16'hFFFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int k = 3; k <= 20; k++) begin
      if (k > 3) @(negedge clk);
      if (done1 === 1'b1) begin lat = k; break; end
    end
    n_checks++;
    if ({lat, sum1, cout1} !== {32'd5, 16'h5555, 1'b0}) begin
      n_fail++; $display("FAIL start_in_run: got lat=%0d sum=%h cout=%b need 5 5555 0", lat, sum1, cout1);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy1, sum1} !== {1'b0, 16'h5555}) begin
      n_fail++; $display("FAIL start_in_run_noqueue: got busy=%b sum=%h need 0 5555", busy1, sum1);
    end
  endtask

  task automatic test_reset_in_run;
    int lat, width, seen;
    launch1(16'h1111, 16'h2222, 1'b0);
    // Cycle 1; assert rst for the edge that ends cycle 2.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (done1 === 1'b1) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL rst_run_nodone: got %0d done cycles need 0", seen); end
    n_checks++;
    if ({busy1, sum1} !== {1'b0, 16'h0000}) begin
      n_fail++; $display("FAIL rst_run_clear: got busy=%b sum=%h need 0 0000", busy1, sum1);
    end
    launch1(16'h0001, 16'h0001, 1'b0);
    wait_done1(lat, width);
    n_checks++;
    if ({lat, sum1, cout1, ovf1} !== {32'd5, 16'h0002, 2'b00}) begin
      n_fail++; $display("FAIL rst_run_next: got lat=%0d sum=%h cout=%b ovf=%b need 5 0002 0 0", lat, sum1, cout1, ovf1);
    end
  endtask

  task automatic test_settle3;
    logic [3:0] ea [12] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] eb [12] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic       ec [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int lat;
    @(negedge clk);
    a_in = 16'h00FF; b_in = 16'h0001; cin = 1'b0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= 12) begin
        n_checks++;
        if ({cla_a2, cla_b2, cla_c2} !== {ea[k-1], eb[k-1], ec[k-1]}) begin
          n_fail++; $display("FAIL settle3_slice cycle %0d: got a=%h b=%h c=%b need a=%h b=%h c=%b",
                             k, cla_a2, cla_b2, cla_c2, ea[k-1], eb[k-1], ec[k-1]);
        end
      end
      if (done2 === 1'b1) begin lat = k; break; end
    end
    n_checks++;
    if ({lat, sum2, cout2, ovf2} !== {32'd13, 16'h0100, 2'b00}) begin
      n_fail++; $display("FAIL settle3_result: got lat=%0d sum=%h cout=%b ovf=%b need 13 0100 0 0", lat, sum2, cout2, ovf2);
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry_chain();
    test_overflow();
    test_start_in_run();
    test_reset_in_run();
    test_settle3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
